// File: rtl/gpio_bank_if.sv
// Bus-side signals between the synchronous GPMC front end and the GPIO bank.
// All strobes are active low, as they come out of gpmc_sync.
`timescale 1ns/1ps
interface gpio_bank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;

  modport master (output cs, we, oe, address, data_out, input data_in);
  modport slave  (input cs, we, oe, address, data_out, output data_in);
endinterface

// File: rtl/gpio_bank.sv
// Generic GPIO bank: per-pin direction/output registers with atomic set/clear,
// synchronised inputs, rise/fall edge capture into sticky W1C status, and a
// registered level interrupt. Address = {group[2:0], word}.
`timescale 1ns/1ps
module gpio_bank #(
  parameter int WORD_BITS  = 1,
  parameter int ADDR_WIDTH = WORD_BITS + 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  gpio_bank_if.slave                             bus,
  inout  wire [DATA_WIDTH*(1<<WORD_BITS)-1:0]    io,
  output logic                                   irq
);

  localparam int NWORDS = 1 << WORD_BITS;
  localparam int PINS   = DATA_WIDTH * NWORDS;

  localparam logic [2:0] G_DIR     = 3'd0;
  localparam logic [2:0] G_OUT     = 3'd1;
  localparam logic [2:0] G_OUT_SET = 3'd2;
  localparam logic [2:0] G_OUT_CLR = 3'd3;
  localparam logic [2:0] G_IN      = 3'd4;
  localparam logic [2:0] G_RISE_EN = 3'd5;
  localparam logic [2:0] G_FALL_EN = 3'd6;
  localparam logic [2:0] G_STATUS  = 3'd7;

  logic [NWORDS-1:0][DATA_WIDTH-1:0] dir_r, out_r, rise_en, fall_en, status;
  logic [NWORDS-1:0][DATA_WIDTH-1:0] status_next, clr;
  logic [NWORDS-1:0][DATA_WIDTH-1:0] s1, s2, s3;
  logic [PINS-1:0]                   rise, fall, dir_flat, out_flat;
  logic [2:0]                        grp;
  logic [WORD_BITS-1:0]              wsel;
  logic                              w_now, w_q, w_pulse, r_now;
  logic [1:0]                        prime;
  logic                              primed;
  logic [DATA_WIDTH-1:0]             rd_word;

  // Bus decode: a write acts only on the first cycle the write condition holds,
  // so a long strobe cannot repeat a set/clear/W1C.
  always_comb begin
    grp     = bus.address[ADDR_WIDTH-1 -: 3];
    wsel    = bus.address[WORD_BITS-1:0];
    w_now   = !bus.cs && !bus.we && bus.oe;
    r_now   = !bus.cs && bus.we && !bus.oe;
    w_pulse = w_now && !w_q;
  end

  // Remember last cycle's write condition for the rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= 1'b0;
    else        w_q <= w_now;
  end

  // Configuration and output registers, including atomic set/clear of OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r   <= '0;
      out_r   <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (w_pulse) begin
      case (grp)
        G_DIR:     dir_r[wsel]   <= bus.data_out;
        G_OUT:     out_r[wsel]   <= bus.data_out;
        G_OUT_SET: out_r[wsel]   <= out_r[wsel] | bus.data_out;
        G_OUT_CLR: out_r[wsel]   <= out_r[wsel] & ~bus.data_out;
        G_RISE_EN: rise_en[wsel] <= bus.data_out;
        G_FALL_EN: fall_en[wsel] <= bus.data_out;
        default:   ;
      endcase
    end
  end

  // Pad drivers: a pin drives only while its direction bit is set.
  assign dir_flat = dir_r;
  assign out_flat = out_r;
  for (genvar i = 0; i < PINS; i++) begin : g_pad
    assign io[i] = dir_flat[i] ? out_flat[i] : 1'bz;
  end

  // Two-flop synchroniser plus a delay flop for edge detection; the prime
  // counter hides the edges the synchroniser produces while filling after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      prime <= 2'd0;
    end else begin
      s1 <= io;
      s2 <= s1;
      s3 <= s2;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  // Sticky status: a fresh edge beats a simultaneous clear of the same bit.
  always_comb begin
    primed = (prime == 2'd3);
    rise   = s2 & ~s3 & {PINS{primed}};
    fall   = ~s2 & s3 & {PINS{primed}};
    clr    = '0;
    if (w_pulse && grp == G_STATUS) clr[wsel] = bus.data_out;
    status_next = (status & ~clr) | (rise & rise_en) | (fall & fall_en);
  end

  // Status register and interrupt, both taken from the same next value so irq
  // rises and falls on the edge that changes status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= status_next;
      irq    <= |status_next;
    end
  end

  // Read mux; set/clear groups read back OUT.
  always_comb begin
    rd_word = '0;
    case (grp)
      G_DIR:                       rd_word = dir_r[wsel];
      G_OUT, G_OUT_SET, G_OUT_CLR: rd_word = out_r[wsel];
      G_IN:                        rd_word = s2[wsel];
      G_RISE_EN:                   rd_word = rise_en[wsel];
      G_FALL_EN:                   rd_word = fall_en[wsel];
      default:                     rd_word = status[wsel];
    endcase
  end

  // Registered read data, zero whenever no read is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     bus.data_in <= '0;
    else if (r_now) bus.data_in <= rd_word;
    else            bus.data_in <= '0;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (WORD_BITS=1): reads go through a scoreboard
// queue, pad and irq timing are checked directly.
`timescale 1ns/1ps
module tb_gpio_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq;
  logic [31:0] ext_drv;
  logic [31:0] ext_en;
  wire  [31:0] io;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  gpio_bank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

  gpio_bank #(.WORD_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .io    (io),
    .irq   (irq)
  );

  for (genvar i = 0; i < 32; i++) begin : g_ext
    assign io[i] = ext_en[i] ? ext_drv[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input int hold);
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1; bus.address = a; bus.data_out = d;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b1; bus.oe = 1'b0; bus.address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), {16'h0, bus.data_in}, {16'h0, exp_q.pop_front()});
    bus_idle();
  endtask

  initial begin
    logic [15:0] post_rst[16];

    bus_idle();
    bus.address  = '0;
    bus.data_out = '0;
    ext_en  = 32'hFFFF_FFFF;
    ext_drv = 32'h0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_data_in", {16'h0, bus.data_in}, 32'h0);

    // Reset defaults: every address reads zero, pads follow the external drive.
    for (int a = 0; a < 16; a++)
      do_read(a[3:0], 16'h0000, $sformatf("rst_read_%0d", a));
    check("rst_pads", io, 32'h0);

    // Pad high through reset with rise enabled on the first post-reset edge.
    @(negedge clk);
    rst_n = 1'b0;
    ext_drv[0] = 1'b1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1; bus.address = 4'd10; bus.data_out = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    repeat (6) @(posedge clk);
    #1;
    check("prime_irq", {31'h0, irq}, 32'h0);
    do_read(4'd14, 16'h0000, "prime_status");
    do_read(4'd10, 16'hFFFF, "rise_en0");
    do_write(4'd10, 16'h0000, 1);
    ext_drv[0]  = 1'b0;
    ext_en[7:0] = 8'h00;

    // Drive and readback.
    do_write(4'd0, 16'h00FF, 1);
    do_write(4'd2, 16'h00A5, 1);
    check("pad_drive", {24'h0, io[7:0]}, 32'hA5);
    do_write(4'd4, 16'h0100, 1);
    do_write(4'd6, 16'h0001, 1);
    do_read(4'd2, 16'h01A4, "out0");
    do_read(4'd4, 16'h01A4, "out_set_read");
    @(negedge clk);
    ext_drv[15:8] = 8'h3C;
    repeat (2) @(posedge clk);
    do_read(4'd8, 16'h3CA4, "in0");

    // Held write strobe on OUT_SET.
    do_write(4'd5, 16'h0001, 10);
    do_read(4'd3, 16'h0001, "out1_held");

    // Edge detection on word 1.
    @(negedge clk);
    ext_drv[16] = 1'b1;
    repeat (4) @(posedge clk);
    do_write(4'd11, 16'h8000, 1);
    do_write(4'd13, 16'h0001, 1);
    do_read(4'd11, 16'h8000, "rise_en1");
    do_read(4'd13, 16'h0001, "fall_en1");
    @(negedge clk);
    ext_drv[31] = 1'b1;
    @(posedge clk); #1; check("irq_lat1", {31'h0, irq}, 32'h0);
    @(posedge clk); #1; check("irq_lat2", {31'h0, irq}, 32'h0);
    @(posedge clk); #1; check("irq_lat3", {31'h0, irq}, 32'h1);
    do_read(4'd15, 16'h8000, "status_rise");
    @(negedge clk);
    ext_drv[16] = 1'b0;
    repeat (4) @(posedge clk);
    do_read(4'd15, 16'h8001, "status_fall");
    @(negedge clk);
    ext_drv[17] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    ext_drv[17] = 1'b0;
    repeat (4) @(posedge clk);
    do_read(4'd15, 16'h8001, "status_not_enabled");

    // Held W1C clears only the written bit, once.
    do_write(4'd15, 16'h0001, 10);
    do_read(4'd15, 16'h8000, "w1c_held");
    check("w1c_held_irq", {31'h0, irq}, 32'h1);

    // Re-arm both bits.
    @(negedge clk); ext_drv[31] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); ext_drv[16] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); ext_drv[16] = 1'b0;
    repeat (4) @(posedge clk);
    do_read(4'd15, 16'h8001, "status_rearm");

    // Clear colliding with a new rise on pad 31: the rise wins.
    @(negedge clk);
    ext_drv[31] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    do_write(4'd15, 16'h8001, 1);
    check("coll_irq", {31'h0, irq}, 32'h1);
    do_read(4'd15, 16'h8000, "coll_status");
    do_write(4'd15, 16'h8000, 1);
    check("clr_irq", {31'h0, irq}, 32'h0);
    do_read(4'd15, 16'h0000, "clr_status");

    // A held W1C must not swallow an edge that arrives while still held.
    @(negedge clk); ext_drv[31] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); ext_drv[31] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1; bus.address = 4'd15; bus.data_out = 16'h8000;
    @(posedge clk);
    @(negedge clk); ext_drv[31] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); ext_drv[31] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus_idle();
    do_read(4'd15, 16'h8000, "w1c_once");

    // Clearing the enable leaves captured status alone.
    do_write(4'd11, 16'h0000, 1);
    do_read(4'd15, 16'h8000, "en_clear_keeps");
    check("en_clear_irq", {31'h0, irq}, 32'h1);

    // Reset in the middle of a held write with all word-0 pins driven.
    @(negedge clk);
    ext_en[15:0] = 16'h0000;
    do_write(4'd0, 16'hFFFF, 1);
    check("drive_all", {16'h0, io[15:0]}, {16'h0, 16'h01A4});
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1; bus.address = 4'd2; bus.data_out = 16'hFFFF;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    ext_drv[15:0] = 16'h5A5A;
    ext_en[15:0]  = 16'hFFFF;
    #1;
    check("rst_mid_pads_z", {16'h0, io[15:0]}, {16'h0, 16'h5A5A});
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) post_rst[a] = 16'h0000;
    post_rst[8] = 16'h5A5A;
    post_rst[9] = 16'h8000;
    for (int a = 0; a < 16; a++)
      do_read(a[3:0], post_rst[a], $sformatf("post_rst_read_%0d", a));
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised GPIO bank that replaces fixed 48-pin, 6-port GPIO glue with a generic bank of 16-pin words. It sits behind `gpmc_sync` on the GPMC bus and provides per-pin direction and output registers. It adds atomic set/clear of outputs, synchronised inputs, per-pin rising/falling edge detection with sticky write-1-to-clear status, and a single level interrupt line towards the host.

## Interface
Parameters:
- `WORD_BITS`, default 1: log2 of the number of 16-bit pin words; `NWORDS = 1 << WORD_BITS`, `PINS = 16*NWORDS`.
- `ADDR_WIDTH`, default `WORD_BITS+3`: bus word address width; must equal `WORD_BITS+3`.
- `DATA_WIDTH`, default 16: bus data width; fixed at 16.

Ports (reset is asynchronous, active-low; one clock):
- `clk` in 1: system clock, same clock as `gpmc_sync`.
- `rst_n` in 1: asynchronous active-low reset.
- `cs` in 1: bus chip select from `gpmc_sync`, active low.
- `we` in 1: bus write strobe, active low.
- `oe` in 1: bus read strobe, active low.
- `address` in `ADDR_WIDTH`: word address = `{group[2:0], word[WORD_BITS-1:0]}`.
- `data_out` in 16: write data from the bus controller.
- `data_in` out 16: registered read data to the bus controller.
- `io` inout `PINS`: pads; `io[16*w+b]` is bit b of word w.
- `irq` out 1: level interrupt, high while any status bit is set.

## Operation
- **Groups.**
  - 0 DIR: RW; 1 = drive pad.
  - 1 OUT: RW.
  - 2 OUT_SET: W, `OUT |= data`; reads return OUT.
  - 3 OUT_CLR: W, `OUT &= ~data`; reads return OUT.
  - 4 IN: RO; synchronised pad value; writes ignored.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 STATUS: read returns sticky edge bits; write-1-to-clear.
- **Pads.** `io[i] = DIR[i] ? OUT[i] : 1'bz`. IN reflects the pad even when the pin is driven (readback).
- **Write condition.** `W = !cs && !we && oe`. The write is executed once, on the first clock where W is true (W rising, tracked by a registered copy of W). Holding W for many cycles causes no further effect. This matters for SET/CLR/W1C.
- **Read condition.** `R = !cs && we && !oe`. Each clock with R true: `data_in <= reg[group][word]`. Otherwise `data_in <= 0`. Reads have no side effects; STATUS is not cleared by a read.
- **Input path.** 2-flop synchroniser per pin (`s1`, `s2`), then a delay flop `s3`.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
- **Status update, per bit per clock:**
  - `next = (STATUS & ~clr) | (rise & RISE_EN) | (fall & FALL_EN)`.
  - `clr` is the one-shot W1C mask, nonzero only on the write cycle to group 7.
  - A new edge in the same cycle as a clear of that bit wins: the bit stays 1.
- **Enables.** Clearing an enable does not clear already-set STATUS bits.
- **Edge priming.** A 2-bit counter saturating at 3 counts from reset. Edge detection is masked until it reaches 3, so pads that are high at reset raise no spurious rising edge.
- **Interrupt.** `irq <= |STATUS_next`, i.e. registered.

## Timing
- **Reset values:**
  - DIR, OUT, RISE_EN, FALL_EN, STATUS, `s1`/`s2`/`s3`, prime counter, W-delay flop: all 0.
  - `data_in` = 0; `irq` = 0.
  - All pads Hi-Z.
- **Write.** Registers update on the clock edge ending the first W cycle. The pad is driven the same edge as DIR/OUT update.
- **Read.** `data_in` is valid one clock after R is sampled and tracks the register each cycle while R is held. A read in the cycle after a write returns the new value.
- **Input latency.** A pad change is visible in IN 2 clocks later. STATUS sets on the 3rd edge. `irq` rises on that same edge, because it is registered from STATUS_next.
- **Clear latency.** W1C clears STATUS and drops `irq` on the same edge, unless another enabled bit is set or a new edge coincides.
- **Pulse width.** Pulses shorter than one clock may be missed; this is by design.
- **Reset mid-access.** Everything clears immediately. A write in progress is lost. The prime counter restarts, so edges are masked for 3 clocks after `rst_n` deasserts.

## Test plan
All scenarios use `WORD_BITS=1`; address = group*2 + word.
1. **Reset defaults.** Reset, then read addr 0..15 → every `data_in` = 0, `io` all Z, `irq` = 0; a pad held high through reset → STATUS stays 0 with RISE_EN = FFFF.
2. **Drive and readback.** Write DIR[0] = 00FF, OUT[0] = 00A5 → `io[7:0]` = A5, `io[15:8]` Z. Write OUT_SET[0] = 0100 then OUT_CLR[0] = 0001 → read OUT[0] = 01A4. Read IN[0] 2+ clocks after driving external `io[15:8]` = 3C → 3CA4.
3. **Held write strobe.** Hold W for 10 clocks on OUT_SET[1] = 0001 with OUT[1] = 0 → OUT[1] = 0001. On STATUS with 2 bits set, a held W1C of 0001 clears bit 0 only.
4. **Edge detection.** RISE_EN[1] = 8000, FALL_EN[1] = 0001. Pad 31 goes 0→1 → STATUS[1] = 8000 exactly 3 clocks later, `irq` = 1. Pad 16 goes 1→0 → STATUS[1] = 8001. Pad 17 toggles (not enabled) → no change.
5. **Clear/edge collision.** Write STATUS[1] = 8001 in the same cycle as a new enabled rise on pad 31 → STATUS[1] = 8000, `irq` stays 1. A second clear of 8000 → STATUS = 0, `irq` = 0 on that edge.
6. **Reset mid-operation.** Assert `rst_n` low during a held write with DIR = FFFF → pads Z immediately; after release, all registers read 0.
